poly_voice_alloc: RTL and testbench

POLY_VOICE_ALLOC -- requirements
Module: poly_voice_alloc

---
 rtl/poly_voice_alloc.sv | 219 +++++++++++++++++++++
 tb/tb_poly_voice_alloc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_alloc.sv
// Polyphonic MIDI voice allocator: note-on/off/all-off handling
// with retrigger, lowest-free allocation and LRU voice stealing.
module poly_voice_alloc #(
  parameter int         NUM_VOICES = 8,
  parameter logic [3:0] MIDI_CH    = 4'd0,
  parameter bit         OMNI       = 1'b1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [23:0]             midi_msg,
  input  logic                    midi_msg_rdy,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE, DECODE, SCAN, COMMIT
  } state_e;

  typedef enum logic [1:0] {
    C_IGN, C_ON, C_OFF, C_ALL
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;

  // status, data1[6:0], data2[6:0]
  logic [21:0]   msg_q, msg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          hit_vld_q, hit_vld_d;
  logic [IW-1:0] hit_idx_q, hit_idx_d;
  logic          free_vld_q, free_vld_d;
  logic [IW-1:0] free_idx_q, free_idx_d;
  logic [IW-1:0] old_idx_q, old_idx_d;

  logic [6:0]    note_q [NUM_VOICES];
  logic [6:0]    note_d [NUM_VOICES];
  logic [6:0]    vel_q  [NUM_VOICES];
  logic [6:0]    vel_d  [NUM_VOICES];
  logic [IW-1:0] rank_q [NUM_VOICES];
  logic [IW-1:0] rank_d [NUM_VOICES];

  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic                  overrun_q, overrun_d;

  logic       unused_bits;
  logic [7:0] st;
  logic [6:0] d1;
  logic [6:0] d2;
  logic       ch_ok;
  logic       is_on;
  logic       is_off;
  logic       is_all;
  logic [IW-1:0] tgt;

  assign unused_bits = midi_msg[15] ^ midi_msg[7];

  assign st = msg_q[21:14];
  assign d1 = msg_q[13:7];
  assign d2 = msg_q[6:0];

  assign ch_ok  = OMNI || (st[3:0] == MIDI_CH);
  assign is_on  = ch_ok && st[7:4] == 4'h9 && d2 != 7'd0;
  assign is_off = ch_ok && (st[7:4] == 4'h8 ||
                  (st[7:4] == 4'h9 && d2 == 7'd0));
  assign is_all = ch_ok && st[7:4] == 4'hB && d1 == 7'd123;

  // retrigger beats free voice, free voice beats steal
  assign tgt = hit_vld_q  ? hit_idx_q  :
               free_vld_q ? free_idx_q : old_idx_q;

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    msg_d      = msg_q;
    idx_d      = idx_q;
    hit_vld_d  = hit_vld_q;
    hit_idx_d  = hit_idx_q;
    free_vld_d = free_vld_q;
    free_idx_d = free_idx_q;
    old_idx_d  = old_idx_q;
    note_d     = note_q;
    vel_d      = vel_q;
    rank_d     = rank_q;
    gate_d     = gate_q;
    trig_d     = '0;
    overrun_d  = midi_msg_rdy && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (midi_msg_rdy) begin
          msg_d   = {midi_msg[23:16], midi_msg[14:8],
                     midi_msg[6:0]};
          state_d = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_on:   cls_d = C_ON;
          is_off:  cls_d = C_OFF;
          is_all:  cls_d = C_ALL;
          default: cls_d = C_IGN;
        endcase
        idx_d      = '0;
        hit_vld_d  = 1'b0;
        free_vld_d = 1'b0;
        old_idx_d  = '0;
        state_d    = (cls_d == C_IGN) ? IDLE : SCAN;
      end
      SCAN: begin
        if (!hit_vld_q && gate_q[idx_q] &&
            note_q[idx_q] == d1) begin
          hit_vld_d = 1'b1;
          hit_idx_d = idx_q;
        end
        if (!free_vld_q && !gate_q[idx_q]) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (rank_q[idx_q] == LAST) begin
          old_idx_d = idx_q;
        end
        if (idx_q == LAST) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      COMMIT: begin
        state_d = IDLE;
        unique case (cls_q)
          C_ON: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (rank_q[i] < rank_q[tgt]) begin
                rank_d[i] = rank_q[i] + IW'(1);
              end
            end
            rank_d[tgt] = '0;
            note_d[tgt] = d1;
            vel_d[tgt]  = d2;
            gate_d[tgt] = 1'b1;
            trig_d[tgt] = 1'b1;
          end
          C_OFF: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (gate_q[i] && note_q[i] == d1) begin
                gate_d[i] = 1'b0;
              end
            end
          end
          C_ALL: gate_d = '0;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cls_q      <= C_IGN;
      msg_q      <= '0;
      idx_q      <= '0;
      hit_vld_q  <= 1'b0;
      hit_idx_q  <= '0;
      free_vld_q <= 1'b0;
      free_idx_q <= '0;
      old_idx_q  <= '0;
      gate_q     <= '0;
      trig_q     <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= IW'(i);
      end
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      msg_q      <= msg_d;
      idx_q      <= idx_d;
      hit_vld_q  <= hit_vld_d;
      hit_idx_q  <= hit_idx_d;
      free_vld_q <= free_vld_d;
      free_idx_q <= free_idx_d;
      old_idx_q  <= old_idx_d;
      gate_q     <= gate_d;
      trig_q     <= trig_d;
      overrun_q  <= overrun_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      rank_q     <= rank_d;
    end
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_q[i];
      voice_vel[7*i +: 7]  = vel_q[i];
    end
  end

  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Scoreboard bench for poly_voice_alloc: stimulus pushes expected
// voice state, a negedge monitor pops it when busy falls.
module tb_poly_voice_alloc;

  localparam int N = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [23:0]    midi_msg = '0;
  logic           rdy = 1'b0;
  logic [7*N-1:0] v_note, v_vel;
  logic [N-1:0]   v_gate, v_trig;
  logic           busy, overrun;

  logic [23:0]    msg2 = '0;
  logic           rdy2 = 1'b0;
  logic [7*N-1:0] note2, vel2;
  logic [N-1:0]   gate2, trig2;
  logic           busy2, ov2;

  poly_voice_alloc #(.NUM_VOICES(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .midi_msg(midi_msg), .midi_msg_rdy(rdy),
    .voice_note(v_note), .voice_vel(v_vel),
    .voice_gate(v_gate), .voice_trig(v_trig),
    .busy(busy), .overrun(overrun)
  );

  poly_voice_alloc #(
    .NUM_VOICES(N), .MIDI_CH(4'd2), .OMNI(1'b0)
  ) dut2 (
    .CLK(CLK), .nRST(nRST),
    .midi_msg(msg2), .midi_msg_rdy(rdy2),
    .voice_note(note2), .voice_vel(vel2),
    .voice_gate(gate2), .voice_trig(trig2),
    .busy(busy2), .overrun(ov2)
  );

  typedef struct packed {
    logic [7*N-1:0] note;
    logic [7*N-1:0] vel;
    logic [N-1:0]   gate;
    logic [N-1:0]   trig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_miss = 0;

  int m_note [N];
  int m_vel  [N];
  int m_rank [N];
  bit m_gate [N];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0;
      m_vel[i]  = 0;
      m_rank[i] = i;
      m_gate[i] = 1'b0;
    end
  endtask

  function automatic exp_t snap(int tgt);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.note[7*i +: 7] = 7'(m_note[i]);
      e.vel[7*i +: 7]  = 7'(m_vel[i]);
      e.gate[i]        = m_gate[i];
    end
    if (tgt >= 0) e.trig[tgt] = 1'b1;
    return e;
  endfunction

  // behavioural reference; channel is don't-care (OMNI dut)
  task automatic model(input logic [23:0] m);
    logic [3:0] hi;
    int n, v, tgt, r;
    hi  = m[23:20];
    n   = int'(m[14:8]);
    v   = int'(m[6:0]);
    tgt = -1;
    if (hi == 4'h9 && v != 0) begin
      for (int i = 0; i < N; i++)
        if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
      for (int i = 0; i < N; i++)
        if (tgt < 0 && !m_gate[i]) tgt = i;
      for (int i = 0; i < N; i++)
        if (tgt < 0 && m_rank[i] == N - 1) tgt = i;
      r = m_rank[tgt];
      for (int i = 0; i < N; i++)
        if (m_rank[i] < r) m_rank[i]++;
      m_rank[tgt] = 0;
      m_note[tgt] = n;
      m_vel[tgt]  = v;
      m_gate[tgt] = 1'b1;
    end else if (hi == 4'h8 || hi == 4'h9) begin
      for (int i = 0; i < N; i++)
        if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
    end else if (hi == 4'hB && n == 123) begin
      for (int i = 0; i < N; i++) m_gate[i] = 1'b0;
    end
    sb.push_back(snap(tgt));
  endtask

  task automatic strobe(input logic [23:0] m);
    @(posedge CLK); #1;
    midi_msg = m;
    rdy = 1'b1;
    @(posedge CLK); #1;
    rdy = 1'b0;
  endtask

  task automatic strobe2(input logic [23:0] m);
    @(posedge CLK); #1;
    msg2 = m;
    rdy2 = 1'b1;
    @(posedge CLK); #1;
    rdy2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int cnt;
    cnt = 0;
    while ((sel ? busy2 : busy) && cnt < 60) begin
      @(posedge CLK); #1;
      cnt++;
    end
    if (cnt >= 60) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic send(input logic [23:0] m);
    model(m);
    strobe(m);
    wait_idle(1'b0);
  endtask

  task automatic send2(input logic [23:0] m);
    strobe2(m);
    wait_idle(1'b1);
  endtask

  logic prev_b = 1'b0;
  always @(negedge CLK) begin
    if (!nRST) begin
      prev_b = 1'b0;
    end else begin
      if (prev_b && !busy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("note", 64'(v_note), 64'(mon_e.note));
          chk("vel",  64'(v_vel),  64'(mon_e.vel));
          chk("gate", 64'(v_gate), 64'(mon_e.gate));
          chk("trig", 64'(v_trig), 64'(mon_e.trig));
        end
      end
      prev_b = busy;
    end
  end

  initial begin
    model_reset();
    #3;
    chk("rst_note", 64'(v_note), 64'd0);
    chk("rst_vel",  64'(v_vel),  64'd0);
    chk("rst_gate", 64'(v_gate), 64'd0);
    chk("rst_trig", 64'(v_trig), 64'd0);
    chk("rst_busy", 64'(busy),   64'd0);
    chk("rst_ovr",  64'(overrun), 64'd0);
    #9 nRST = 1'b1;

    // first note-on with exact latency
    model(24'h903C64);
    strobe(24'h903C64);
    repeat (N + 1) begin @(posedge CLK); #1; end
    chk("busy_hold", 64'(busy), 64'd1);
    @(posedge CLK); #1;
    chk("busy_done", 64'(busy), 64'd0);
    chk("v0_note", 64'(v_note[6:0]), 64'd60);
    chk("v0_vel",  64'(v_vel[6:0]),  64'd100);
    chk("trig_on", 64'(v_trig), 64'h01);
    @(posedge CLK); #1;
    chk("trig_off", 64'(v_trig), 64'h00);

    for (int k = 61; k <= 68; k++)
      send({8'h90, 8'(k), 8'h64});
    chk("steal_v0", 64'(v_note[6:0]), 64'd68);
    chk("steal_v1", 64'(v_note[13:7]), 64'd61);
    chk("steal_g",  64'(v_gate), 64'hFF);

    send(24'hB07B00);
    chk("alloff_g", 64'(v_gate), 64'h00);
    send(24'h903C64);
    send(24'h903C32);
    chk("retrig_vel", 64'(v_vel[6:0]), 64'd50);
    chk("retrig_g",   64'(v_gate), 64'h01);
    send(24'h903C00);
    chk("off_v0_g", 64'(v_gate), 64'h00);

    send(24'h90BEFF);
    chk("b7_note", 64'(v_note[6:0]), 64'd62);
    chk("b7_vel",  64'(v_vel[6:0]),  64'd127);
    send(24'h91BE80);
    chk("b7_off", 64'(v_gate), 64'h00);
    send(24'h905564);
    send(24'h803700);
    send(24'hC00500);
    send(24'hB07A00);

    // second strobe three cycles after the first is dropped
    send(24'hB07B00);
    model(24'h904664);
    strobe(24'h904664);
    repeat (2) begin @(posedge CLK); #1; end
    midi_msg = 24'h904764;
    rdy = 1'b1;
    @(posedge CLK); #1;
    rdy = 1'b0;
    chk("ovr_pulse", 64'(overrun), 64'd1);
    @(posedge CLK); #1;
    chk("ovr_clear", 64'(overrun), 64'd0);
    wait_idle(1'b0);
    chk("ovr_gate", 64'(v_gate), 64'h01);
    chk("ovr_note", 64'(v_note[6:0]), 64'd70);

    // reset in the middle of a scan
    strobe(24'h904864);
    repeat (3) begin @(posedge CLK); #1; end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_gate", 64'(v_gate), 64'd0);
    chk("mid_rst_note", 64'(v_note), 64'd0);
    chk("mid_rst_vel",  64'(v_vel),  64'd0);
    model_reset();
    #6 nRST = 1'b1;
    send(24'h904864);
    chk("post_rst_v0", 64'(v_note[6:0]), 64'd72);
    chk("post_rst_g",  64'(v_gate), 64'h01);

    // channel-filtered instance
    send2(24'h913C64);
    chk("ch_ign_g", 64'(gate2), 64'h00);
    send2(24'h923C64);
    chk("ch_on_g", 64'(gate2), 64'h01);
    chk("ch_on_n", 64'(note2[6:0]), 64'd60);
    send2(24'hB27B00);
    chk("ch_all_g", 64'(gate2), 64'h00);

    @(negedge CLK); #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
